// File: rtl/seq_divider_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_divider_if -- start/operand request and busy/done/result bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_divider -- unsigned N/N restoring divider, one quotient bit per clock
// Revision 1.0
// ----------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus_io
);
  localparam int            CW           = $clog2(N + 1);
  localparam logic [CW-1:0] C_COUNT_INIT = CW'(N);
  localparam logic [CW-1:0] C_COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    s_w;
  logic [N+1:0]  sum_w;
  logic          carry_w;
  logic          unused_t_msb;
  logic [N-1:0]  r_next_w;
  logic [N-1:0]  q_next_w;

  // Subtractor stage: S + ~D + 1, the extra top bit is the no-borrow carry.
  assign s_w          = {r_q, q_q[N-1]};
  assign sum_w        = {1'b0, s_w} + {1'b0, ~{1'b0, d_q}} + {{(N+1){1'b0}}, 1'b1};
  assign carry_w      = sum_w[N+1];
  assign unused_t_msb = sum_w[N];
  assign r_next_w     = carry_w ? sum_w[N-1:0] : s_w[N-1:0];
  assign q_next_w     = {q_q[N-2:0], carry_w};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      RUN: begin
        r_d   = r_next_w;
        q_d   = q_next_w;
        cnt_d = cnt_q - C_COUNT_ONE;
        if (cnt_q == C_COUNT_ONE) begin
          state_d = DONE;
          quot_d  = q_next_w;
          rem_d   = r_next_w;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE accept a new request under identical rules.
        state_d = IDLE;
        if (bus_io.start) begin
          if (bus_io.divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus_io.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            r_d     = '0;
            q_d     = bus_io.dividend;
            d_d     = bus_io.divisor;
            cnt_d   = C_COUNT_INIT;
          end
        end
      end
    endcase
  end

  assign bus_io.busy        = (state_q == RUN);
  assign bus_io.done        = (state_q == DONE);
  assign bus_io.quotient    = quot_q;
  assign bus_io.remainder   = rem_q;
  assign bus_io.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_divider -- vector table, corner sequences and random sweep vs model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_seq_divider;
  logic clk;
  logic rst;

  seq_divider_if #(.N(32)) if32 ();
  seq_divider_if #(.N(8))  if8  ();

  seq_divider #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .bus_io(if32));
  seq_divider #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus_io(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t        tbl [8];
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [31:0] prev_q    = '0;
  logic [31:0] prev_r    = '0;
  logic        prev_dbz  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request for one cycle; operands are scrambled after acceptance.
  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs);
    if32.start    = 1'b1;
    if32.dividend = dvd;
    if32.divisor  = dvs;
    @(posedge clk); #1;
    if32.start    = 1'b0;
    if32.dividend = $urandom;
    if32.divisor  = $urandom;
  endtask

  // Called in cycle 1; returns inside the DONE cycle after checking it.
  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz, input int pulse_cyc);
    int   cyc       = 1;
    logic busy_ok   = 1'b1;
    logic stable_ok = 1'b1;
    while (!if32.done && cyc < 40) begin
      if (!if32.busy) busy_ok = 1'b0;
      if (if32.quotient !== prev_q || if32.remainder !== prev_r || if32.div_by_zero !== prev_dbz)
        stable_ok = 1'b0;
      if (cyc == pulse_cyc) begin
        if32.start    = 1'b1;
        if32.dividend = 32'd50;
        if32.divisor  = 32'd3;
      end else begin
        if32.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if32.start = 1'b0;
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({name, "_hold"}, {31'd0, stable_ok}, 32'd1);
    chk({name, "_busy_done"}, {31'd0, if32.busy}, 32'd0);
    chk({name, "_q"}, if32.quotient, eq);
    chk({name, "_r"}, if32.remainder, er);
    chk({name, "_dbz"}, {31'd0, if32.div_by_zero}, {31'd0, edbz});
    prev_q   = eq;
    prev_r   = er;
    prev_dbz = edbz;
  endtask

  initial begin
    logic [31:0] a, b, mq, mr;
    logic [7:0]  a8, b8, mq8, mr8;
    int          cyc;
    logic        no_done;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,      1'b0};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0};
    tbl[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0};
    tbl[3] = '{32'd5,          32'd9,          32'd0,          32'd5,      1'b0};
    tbl[4] = '{32'd0,          32'd3,          32'd0,          32'd0,      1'b0};
    tbl[5] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,   1'b1};
    tbl[6] = '{32'd20,         32'd4,          32'd5,          32'd0,      1'b0};
    tbl[7] = '{32'd1_000_000,  32'd999,        32'd1001,       32'd1,      1'b0};

    rst = 1'b1;
    if32.start = 1'b0; if32.dividend = '0; if32.divisor = '0;
    if8.start  = 1'b0; if8.dividend  = '0; if8.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, if32.busy}, 32'd0);
    chk("rst_done", {31'd0, if32.done}, 32'd0);
    chk("rst_q", if32.quotient, 32'd0);
    chk("rst_r", if32.remainder, 32'd0);
    chk("rst_dbz", {31'd0, if32.div_by_zero}, 32'd0);
    chk("rst_n8", {if8.quotient, if8.remainder, 13'd0, if8.busy, if8.done, if8.div_by_zero},
        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].dvd, tbl[i].dvs);
      wait_done($sformatf("vec%0d", i), (tbl[i].dvs == 0) ? 1 : 33,
                tbl[i].q, tbl[i].r, tbl[i].dbz, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle", i), {30'd0, if32.busy, if32.done}, 32'd0);
    end

    // Mid-run start is ignored; start held in DONE is accepted back-to-back.
    issue(32'd1000, 32'd10);
    wait_done("ignore", 33, 32'd100, 32'd0, 1'b0, 10);
    issue(32'd50, 32'd3);
    wait_done("b2b", 33, 32'd16, 32'd2, 1'b0, 0);
    @(posedge clk); #1;

    // Reset in cycle 15 aborts the divide with no done pulse.
    issue(32'd1000, 32'd10);
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_outs", if32.quotient | if32.remainder |
        {29'd0, if32.busy, if32.done, if32.div_by_zero}, 32'd0);
    no_done = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (if32.done) no_done = 1'b0;
    end
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (if32.done) no_done = 1'b0;
    end
    chk("abort_no_done", {31'd0, no_done}, 32'd1);
    prev_q = '0; prev_r = '0; prev_dbz = 1'b0;
    issue(32'd77, 32'd7);
    wait_done("after_rst", 33, 32'd11, 32'd0, 1'b0, 0);

    // Random sweep, N=32, against plain division.
    for (int k = 0; k < 300; k++) begin
      a = $urandom;
      case (k % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = (k % 16 == 3) ? 32'd0 : (a >> $urandom_range(0, 4));
      endcase
      if (b == 0) begin
        mq = 32'hFFFF_FFFF; mr = a;
      end else begin
        mq = a / b; mr = a % b;
      end
      issue(a, b);
      wait_done("rnd32", (b == 0) ? 1 : 33, mq, mr, (b == 0), 0);
    end

    // Random sweep, N=8, back-to-back starts.
    for (int k = 0; k < 1500; k++) begin
      a8 = 8'($urandom);
      b8 = (k % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if (b8 == 0) begin
        mq8 = 8'hFF; mr8 = a8;
      end else begin
        mq8 = a8 / b8; mr8 = a8 % b8;
      end
      if8.start = 1'b1; if8.dividend = a8; if8.divisor = b8;
      @(posedge clk); #1;
      if8.start = 1'b0; if8.dividend = 8'($urandom); if8.divisor = 8'($urandom);
      cyc = 1;
      while (!if8.done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("rnd8_latency", cyc, (b8 == 0) ? 1 : 9);
      chk("rnd8_q", {24'd0, if8.quotient}, {24'd0, mq8});
      chk("rnd8_r", {24'd0, if8.remainder}, {24'd0, mr8});
      chk("rnd8_dbz", {31'd0, if8.div_by_zero}, {31'd0, (b8 == 0)});
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
`default_nettype wire
